// File: rtl/vec_normalize.sv
// vec_normalize: scales Q8.24 vectors to unit length using an external in-order
// inverse-square-root unit; an occupancy credit bounds the pending and output FIFOs.
`ifndef WORD_WIDTH
`define WORD_WIDTH 32
`endif

module vec_normalize #(
   parameter int WIDTH = `WORD_WIDTH,
   parameter int DEPTH = 8
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             in_valid,
   output logic             in_ready,
   input  logic [WIDTH-1:0] in_x,
   input  logic [WIDTH-1:0] in_y,
   input  logic [WIDTH-1:0] in_z,
   output logic             isq_valid,
   output logic [WIDTH-1:0] isq_x,
   input  logic             isq_valid_in,
   input  logic [WIDTH-1:0] isq_result,
   output logic             out_valid,
   input  logic             out_ready,
   output logic [WIDTH-1:0] out_x,
   output logic [WIDTH-1:0] out_y,
   output logic [WIDTH-1:0] out_z,
   output logic             err
);
   localparam int FRAC = WIDTH - 8;
   localparam int AW   = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam int CW   = AW + 1;
   localparam int PW   = 2 * WIDTH;
   localparam logic [WIDTH-1:0] SAT_MAX = {1'b0, {(WIDTH-1){1'b1}}};
   localparam logic [AW-1:0]    PTR_ONE = AW'(1);
   localparam logic [CW-1:0]    DEPTH_C = CW'(DEPTH);

   function automatic logic [PW-1:0] fp_square(input logic [WIDTH-1:0] a);
      logic signed [PW-1:0] p;
      p = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{a[WIDTH-1]}}, a});
      p = p >>> FRAC;
      return p;
   endfunction

   function automatic logic [WIDTH-1:0] fp_mul(input logic [WIDTH-1:0] a, input logic [WIDTH-1:0] b);
      logic signed [PW-1:0] p;
      p = $signed({{WIDTH{a[WIDTH-1]}}, a}) * $signed({{WIDTH{b[WIDTH-1]}}, b});
      p = p >>> FRAC;
      return p[WIDTH-1:0];
   endfunction

   logic             len_valid_r;
   logic [WIDTH-1:0] len_r, lx_r, ly_r, lz_r;
   logic [WIDTH-1:0] pmem_x [DEPTH];
   logic [WIDTH-1:0] pmem_y [DEPTH];
   logic [WIDTH-1:0] pmem_z [DEPTH];
   logic             pmem_zero [DEPTH];
   logic [WIDTH-1:0] omem_x [DEPTH];
   logic [WIDTH-1:0] omem_y [DEPTH];
   logic [WIDTH-1:0] omem_z [DEPTH];
   logic [AW-1:0]    pend_wr_r, pend_rd_r, out_wr_r, out_rd_r;
   logic [CW-1:0]    pend_cnt_r, out_cnt_r;
   logic             ready_r, err_r;

   logic             accept_s, pend_pop_s, spurious_s, out_pop_s;
   logic [PW+1:0]    sum_s;
   logic [WIDTH-1:0] len2_s;
   logic [CW-1:0]    pend_next_s, out_next_s, occ_next_s;
   logic [WIDTH-1:0] nx_s, ny_s, nz_s;

   // Squared length; all terms are non-negative, so clamping the exact sum covers every partial sum.
   always_comb begin
      sum_s = {2'b00, fp_square(in_x)} + {2'b00, fp_square(in_y)} + {2'b00, fp_square(in_z)};
      if (sum_s > {{(PW+2-WIDTH){1'b0}}, SAT_MAX}) begin
         len2_s = SAT_MAX;
      end else begin
         len2_s = sum_s[WIDTH-1:0];
      end
   end

   // Handshakes and next-cycle occupancy used to register in_ready.
   always_comb begin
      accept_s    = in_valid & ready_r;
      pend_pop_s  = isq_valid_in & (pend_cnt_r != {CW{1'b0}});
      spurious_s  = isq_valid_in & (pend_cnt_r == {CW{1'b0}});
      out_pop_s   = out_ready & (out_cnt_r != {CW{1'b0}});
      pend_next_s = pend_cnt_r + CW'(len_valid_r) - CW'(pend_pop_s);
      out_next_s  = out_cnt_r + CW'(pend_pop_s) - CW'(out_pop_s);
      occ_next_s  = CW'(accept_s) + pend_next_s + out_next_s;
   end

   // Pending head scaled by the returned inverse square root.
   always_comb begin
      if (pmem_zero[pend_rd_r]) begin
         nx_s = {WIDTH{1'b0}};
         ny_s = {WIDTH{1'b0}};
         nz_s = {WIDTH{1'b0}};
      end else begin
         nx_s = fp_mul(pmem_x[pend_rd_r], isq_result);
         ny_s = fp_mul(pmem_y[pend_rd_r], isq_result);
         nz_s = fp_mul(pmem_z[pend_rd_r], isq_result);
      end
   end

   // Length stage: holds each accepted vector for the single request cycle.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         len_valid_r <= 1'b0;
         len_r       <= {WIDTH{1'b0}};
         lx_r        <= {WIDTH{1'b0}};
         ly_r        <= {WIDTH{1'b0}};
         lz_r        <= {WIDTH{1'b0}};
      end else begin
         len_valid_r <= accept_s;
         if (accept_s) begin
            len_r <= len2_s;
            lx_r  <= in_x;
            ly_r  <= in_y;
            lz_r  <= in_z;
         end
      end
   end

   // FIFO pointers, counts, credit and sticky error.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         pend_wr_r  <= {AW{1'b0}};
         pend_rd_r  <= {AW{1'b0}};
         out_wr_r   <= {AW{1'b0}};
         out_rd_r   <= {AW{1'b0}};
         pend_cnt_r <= {CW{1'b0}};
         out_cnt_r  <= {CW{1'b0}};
         ready_r    <= 1'b0;
         err_r      <= 1'b0;
      end else begin
         if (len_valid_r) begin
            pend_wr_r <= pend_wr_r + PTR_ONE;
         end
         if (pend_pop_s) begin
            pend_rd_r <= pend_rd_r + PTR_ONE;
            out_wr_r  <= out_wr_r + PTR_ONE;
         end
         if (out_pop_s) begin
            out_rd_r <= out_rd_r + PTR_ONE;
         end
         pend_cnt_r <= pend_next_s;
         out_cnt_r  <= out_next_s;
         ready_r    <= (occ_next_s < DEPTH_C);
         err_r      <= err_r | spurious_s;
      end
   end

   // FIFO storage; entries are meaningful only while covered by the matching count.
   always_ff @(posedge clk) begin
      if (len_valid_r) begin
         pmem_x[pend_wr_r]    <= lx_r;
         pmem_y[pend_wr_r]    <= ly_r;
         pmem_z[pend_wr_r]    <= lz_r;
         pmem_zero[pend_wr_r] <= (len_r == {WIDTH{1'b0}});
      end
      if (pend_pop_s) begin
         omem_x[out_wr_r] <= nx_s;
         omem_y[out_wr_r] <= ny_s;
         omem_z[out_wr_r] <= nz_s;
      end
   end

   assign in_ready  = ready_r;
   assign isq_valid = len_valid_r;
   assign isq_x     = len_r;
   assign err       = err_r;
   assign out_valid = (out_cnt_r != {CW{1'b0}});
   assign out_x     = out_valid ? omem_x[out_rd_r] : {WIDTH{1'b0}};
   assign out_y     = out_valid ? omem_y[out_rd_r] : {WIDTH{1'b0}};
   assign out_z     = out_valid ? omem_z[out_rd_r] : {WIDTH{1'b0}};

endmodule

// File: tb/tb_vec_normalize.sv
// Bench for vec_normalize: directed vector table, hand-written corner sequences and a
// random stream with an in-order inverse-square-root model and a queue scoreboard.
module tb_vec_normalize;
   logic        clk = 1'b0;
   logic        rst = 1'b0;
   logic        in_valid = 1'b0;
   logic        in_ready;
   logic [31:0] in_x = 32'd0, in_y = 32'd0, in_z = 32'd0;
   logic        isq_valid;
   logic [31:0] isq_x;
   logic        isq_valid_in = 1'b0;
   logic [31:0] isq_result = 32'd0;
   logic        out_valid;
   logic        out_ready = 1'b1;
   logic [31:0] out_x, out_y, out_z;
   logic        err;

   vec_normalize #(.WIDTH(32), .DEPTH(8)) dut (
      .clk(clk), .rst(rst), .in_valid(in_valid), .in_ready(in_ready),
      .in_x(in_x), .in_y(in_y), .in_z(in_z),
      .isq_valid(isq_valid), .isq_x(isq_x),
      .isq_valid_in(isq_valid_in), .isq_result(isq_result),
      .out_valid(out_valid), .out_ready(out_ready),
      .out_x(out_x), .out_y(out_y), .out_z(out_z), .err(err)
   );

   always #5 clk = ~clk;

   typedef struct { logic [31:0] x, y, z, res, len, ox, oy, oz; } vec_t;
   typedef struct { logic [31:0] x, y, z, len; } v3_t;
   typedef struct { int due; logic [31:0] val; } isq_t;

   vec_t        tbl [8];
   v3_t         acc_q [$];
   v3_t         exo_q [$];
   isq_t        isq_q [$];
   int          checks = 0;
   int          errors = 0;
   int          cyc = 0;
   int          last_due = 0;
   int          mon_pops = 0;
   bit          prev_accept = 1'b0, last_accept = 1'b0, was_rst = 1'b1, err_model = 1'b0;
   bit          spur_req = 1'b0, isq_fixed = 1'b0;
   int          isq_fix_lat = 3;
   logic [31:0] isq_fix_val = 32'd0;
   logic [31:0] prev_len = 32'd0;
   bit          mon_isq_seen = 1'b0, mon_out_seen = 1'b0;
   logic [31:0] mon_isq_x, mon_ox, mon_oy, mon_oz;

   task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%h required=%h (cycle %0d)", name, act, exp, cyc);
      end
   endtask

   function automatic longint ref_sq(input logic [31:0] a);
      longint p;
      p = longint'($signed(a)) * longint'($signed(a));
      return p >>> 24;
   endfunction

   function automatic logic [31:0] ref_len(input logic [31:0] x, input logic [31:0] y, input logic [31:0] z);
      longint s;
      s = ref_sq(x) + ref_sq(y) + ref_sq(z);
      if (s > longint'(32'h7FFFFFFF)) return 32'h7FFFFFFF;
      return s[31:0];
   endfunction

   function automatic logic [31:0] ref_mul(input logic [31:0] a, input logic [31:0] b);
      longint p;
      p = longint'($signed(a)) * longint'($signed(b));
      p = p >>> 24;
      return p[31:0];
   endfunction

   function automatic logic [31:0] rand_comp();
      if ($urandom_range(0, 3) == 0) return $urandom();
      return $urandom_range(0, 32'h0FFFFFFF) - 32'h08000000;
   endfunction

   // Observes one cycle at the falling edge, before the edge that commits it.
   task automatic monitor();
      v3_t  v, e;
      isq_t q;
      int   lat;
      if (rst) begin
         chk("rst_in_ready", 32'(in_ready), 32'd0);
         chk("rst_isq_valid", 32'(isq_valid), 32'd0);
         chk("rst_isq_x", isq_x, 32'd0);
         chk("rst_out_valid", 32'(out_valid), 32'd0);
         chk("rst_out_xyz", out_x | out_y | out_z, 32'd0);
         chk("rst_err", 32'(err), 32'd0);
         acc_q.delete(); exo_q.delete(); isq_q.delete();
         prev_accept = 1'b0; last_accept = 1'b0; err_model = 1'b0; was_rst = 1'b1; last_due = 0;
      end else begin
         chk("in_ready", 32'(in_ready),
             32'((!was_rst) && ((acc_q.size() + exo_q.size()) < 8)));
         chk("err", 32'(err), 32'(err_model));
         chk("isq_valid", 32'(isq_valid), 32'(prev_accept));
         if (prev_accept) chk("isq_x", isq_x, prev_len);
         if (isq_valid) begin
            if (!mon_isq_seen) begin mon_isq_seen = 1'b1; mon_isq_x = isq_x; end
            lat = isq_fixed ? isq_fix_lat : int'($urandom_range(1, 6));
            q.due = cyc + lat;
            if (q.due <= last_due) q.due = last_due + 1;
            last_due = q.due;
            q.val = isq_fixed ? isq_fix_val : $urandom();
            isq_q.push_back(q);
         end
         chk("out_valid", 32'(out_valid), 32'(exo_q.size() > 0));
         if (out_valid && exo_q.size() > 0) begin
            if (!mon_out_seen) begin mon_out_seen = 1'b1; mon_ox = out_x; mon_oy = out_y; mon_oz = out_z; end
            chk("out_x", out_x, exo_q[0].x);
            chk("out_y", out_y, exo_q[0].y);
            chk("out_z", out_z, exo_q[0].z);
            if (out_ready) begin
               void'(exo_q.pop_front());
               mon_pops++;
            end
         end
         if (isq_valid_in) begin
            if (acc_q.size() == 0) begin
               err_model = 1'b1;
            end else begin
               v = acc_q.pop_front();
               e.len = v.len;
               e.x = (v.len == 32'd0) ? 32'd0 : ref_mul(v.x, isq_result);
               e.y = (v.len == 32'd0) ? 32'd0 : ref_mul(v.y, isq_result);
               e.z = (v.len == 32'd0) ? 32'd0 : ref_mul(v.z, isq_result);
               exo_q.push_back(e);
            end
         end
         last_accept = in_valid && in_ready;
         if (last_accept) begin
            v.x = in_x; v.y = in_y; v.z = in_z;
            v.len = ref_len(in_x, in_y, in_z);
            acc_q.push_back(v);
            prev_len = v.len;
         end
         prev_accept = last_accept;
         was_rst = 1'b0;
      end
   endtask

   // One clock: observe, then drive the inverse-square-root model for the next cycle.
   task automatic step();
      @(negedge clk);
      monitor();
      @(posedge clk);
      cyc++;
      #1;
      if (rst) begin
         isq_valid_in = 1'b0;
         isq_q.delete();
      end else if (isq_q.size() > 0 && isq_q[0].due == cyc) begin
         isq_valid_in = 1'b1;
         isq_result = isq_q[0].val;
         void'(isq_q.pop_front());
      end else if (spur_req) begin
         isq_valid_in = 1'b1;
         isq_result = $urandom();
         spur_req = 1'b0;
      end else begin
         isq_valid_in = 1'b0;
         isq_result = $urandom();
      end
   endtask

   task automatic do_reset(input int n);
      rst = 1'b1;
      in_valid = 1'b0;
      isq_valid_in = 1'b0;
      isq_q.delete();
      for (int k = 0; k < n; k++) step();
      rst = 1'b0;
   endtask

   task automatic drain();
      in_valid = 1'b0;
      out_ready = 1'b1;
      for (int k = 0; k < 300 && (acc_q.size() + exo_q.size()) != 0; k++) step();
      step();
      step();
      chk("drain_empty", 32'(acc_q.size() + exo_q.size()), 32'd0);
      chk("drain_out_valid", 32'(out_valid), 32'd0);
   endtask

   task automatic rand_vec();
      in_x = rand_comp();
      in_y = rand_comp();
      in_z = rand_comp();
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      int acc_n, lat, pops_before;
      tbl[0] = '{32'h03000000, 32'h0, 32'h0, 32'h00555555, 32'h09000000, 32'h00FFFFFF, 32'h0, 32'h0};
      tbl[1] = '{32'h0, 32'h0, 32'h0, 32'h12345678, 32'h0, 32'h0, 32'h0, 32'h0};
      tbl[2] = '{32'h7F000000, 32'h7F000000, 32'h0, 32'h00010000, 32'h7FFFFFFF, 32'h007F0000, 32'h007F0000, 32'h0};
      tbl[3] = '{32'h01000000, 32'h01000000, 32'h01000000, 32'h0093CD3A, 32'h03000000, 32'h0093CD3A, 32'h0093CD3A, 32'h0093CD3A};
      tbl[4] = '{32'hFF000000, 32'h02000000, 32'h0, 32'h00800000, 32'h05000000, 32'hFF800000, 32'h01000000, 32'h0};
      tbl[5] = '{32'h00000001, 32'h0, 32'h0, 32'h7FFFFFFF, 32'h0, 32'h0, 32'h0, 32'h0};
      tbl[6] = '{32'hFFFFFFFF, 32'h01000000, 32'h0, 32'h00800000, 32'h01000000, 32'hFFFFFFFF, 32'h00800000, 32'h0};
      tbl[7] = '{32'h80000000, 32'h0, 32'h0, 32'h00010000, 32'h7FFFFFFF, 32'hFF800000, 32'h0, 32'h0};

      #1;
      do_reset(3);

      // Spurious inverse-square-root return with nothing pending.
      step();
      step();
      spur_req = 1'b1;
      step();
      step();
      step();
      chk("spur_err", 32'(err), 32'd1);
      chk("spur_out_valid", 32'(out_valid), 32'd0);
      step();
      chk("spur_err_sticky", 32'(err), 32'd1);
      do_reset(2);
      chk("err_cleared", 32'(err), 32'd0);
      chk("ready_low_after_release", 32'(in_ready), 32'd0);
      step();
      step();

      // Directed vectors with a fixed latency-3 inverse-square-root unit.
      isq_fixed = 1'b1;
      isq_fix_lat = 3;
      for (int i = 0; i < 8; i++) begin
         isq_fix_val = tbl[i].res;
         mon_isq_seen = 1'b0;
         mon_out_seen = 1'b0;
         in_valid = 1'b1;
         in_x = tbl[i].x; in_y = tbl[i].y; in_z = tbl[i].z;
         step();
         chk("tbl_accept", 32'(last_accept), 32'd1);
         in_valid = 1'b0;
         lat = 0;
         for (int k = 1; k <= 20 && lat == 0; k++) begin
            step();
            if (mon_out_seen) lat = k;
         end
         chk("tbl_isq_x", mon_isq_x, tbl[i].len);
         chk("tbl_latency", 32'(lat), 32'd5);
         chk("tbl_out_x", mon_ox, tbl[i].ox);
         chk("tbl_out_y", mon_oy, tbl[i].oy);
         chk("tbl_out_z", mon_oz, tbl[i].oz);
         step();
      end
      drain();

      // Back-pressure: credit stops acceptance at DEPTH vectors in flight.
      isq_fixed = 1'b0;
      pops_before = mon_pops;
      out_ready = 1'b0;
      acc_n = 0;
      for (int k = 0; k < 40; k++) begin
         in_valid = (acc_n < 10);
         rand_vec();
         step();
         if (last_accept) acc_n++;
      end
      chk("bp_accepts", 32'(acc_n), 32'd8);
      chk("bp_in_ready", 32'(in_ready), 32'd0);
      chk("bp_out_valid", 32'(out_valid), 32'd1);
      out_ready = 1'b1;
      for (int k = 0; k < 60 && acc_n < 10; k++) begin
         in_valid = 1'b1;
         rand_vec();
         step();
         if (last_accept) acc_n++;
      end
      drain();
      chk("bp_total_accepts", 32'(acc_n), 32'd10);
      chk("bp_total_outputs", 32'(mon_pops - pops_before), 32'd10);

      // Sustained throughput with constant latency and no back-pressure.
      isq_fixed = 1'b1;
      isq_fix_lat = 2;
      isq_fix_val = 32'h00800000;
      acc_n = 0;
      for (int k = 0; k < 20; k++) begin
         in_valid = 1'b1;
         rand_vec();
         step();
         if (last_accept) acc_n++;
      end
      chk("throughput", 32'(acc_n), 32'd20);
      drain();

      // Random stream with a reset in the middle.
      isq_fixed = 1'b0;
      for (int k = 0; k < 3000; k++) begin
         if (k == 1500) begin
            do_reset(2);
         end
         in_valid = ($urandom_range(0, 1) == 1);
         rand_vec();
         out_ready = ($urandom_range(0, 3) != 0);
         step();
      end
      pops_before = mon_pops;
      drain();
      chk("rand_err_clear", 32'(err), 32'd0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end
endmodule
